mem_stream_loader: RTL and testbench

- Hardware counterpart of the instruction fetch path. fetch reads the program memory; this block writes it.
- Accepts a byte stream over a valid/ready handshake and packs the bytes MSB-first into DATA_LEN-bit words.
- Writes each word into mem at consecutive addresses starting at 0, then reports completion and the word count so fetch can be started.

---
 rtl/mem_stream_loader.sv | 166 ++++++++++++++++
 tb/tb_mem_stream_loader.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stream_loader.sv
// mem_stream_loader
//   Writes the program memory from a byte stream. Bytes arrive over a
//   valid/ready handshake and are packed MSB-first into DATA_LEN-bit words,
//   which are written to consecutive addresses starting at 0. When the stream
//   ends (byte_last) the block raises done and reports the number of words
//   written, so instruction fetch can be started.
//
// Ports
//   clk         clock, all state changes on the rising edge
//   rst         asynchronous active-low reset
//   start       one-cycle pulse, arms a load from address 0 (IDLE/DONE only)
//   byte_valid  byte_data/byte_last are valid
//   byte_data   stream byte, first byte of each word is the MSB
//   byte_last   final byte of the stream
//   byte_ready  a byte is accepted this cycle when byte_valid is also high
//   mem_wr      memory write strobe, one cycle per word
//   mem_addr    memory write address (holds outside the write cycle)
//   mem_data    memory write data (holds outside the write cycle)
//   word_count  words written in the current or last load
//   done        load finished, held until the next start
//   overflow    stream did not fit in ADDRS words, held until the next start
module mem_stream_loader #(
    parameter int ADDR_LEN = 11,
    parameter int DATA_LEN = 40,
    parameter int ADDRS    = 2 ** ADDR_LEN
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                byte_valid,
    input  logic [7:0]          byte_data,
    input  logic                byte_last,
    output logic                byte_ready,
    output logic                mem_wr,
    output logic [ADDR_LEN-1:0] mem_addr,
    output logic [DATA_LEN-1:0] mem_data,
    output logic [ADDR_LEN:0]   word_count,
    output logic                done,
    output logic                overflow
);

    localparam int CHAR_PART = DATA_LEN / 8;
    localparam int CNT_W     = $clog2(CHAR_PART + 1);
    localparam logic [CNT_W-1:0]    CHAR_PART_C = CNT_W'(CHAR_PART);
    localparam logic [ADDR_LEN-1:0] LAST_ADDR   = ADDR_LEN'(ADDRS - 1);

    typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_LEN-1:0] word_q, word_d;
    logic                last_q, last_d;

    logic                byte_ready_d, mem_wr_d, done_d, overflow_d;
    logic [ADDR_LEN-1:0] mem_addr_d;
    logic [DATA_LEN-1:0] mem_data_d;
    logic [ADDR_LEN:0]   word_count_d;

    logic [DATA_LEN-1:0] packed_word;
    logic [CNT_W-1:0]    cnt_inc;
    logic [CNT_W-1:0]    pad_bytes;

    // Word after shifting in the current byte; a short final word is
    // left-aligned by the number of bytes still missing.
    assign packed_word = {word_q[DATA_LEN-9:0], byte_data};
    assign cnt_inc     = cnt_q + 1'b1;
    assign pad_bytes   = CHAR_PART_C - cnt_inc;

    always_comb begin
        // NOTE: every value produced here is given a default first, so no
        // path through the case statement can leave one unassigned (latch).
        state_d      = state_q;
        cnt_d        = cnt_q;
        word_d       = word_q;
        last_d       = last_q;
        byte_ready_d = byte_ready;
        mem_wr_d     = 1'b0;
        mem_addr_d   = mem_addr;
        mem_data_d   = mem_data;
        word_count_d = word_count;
        done_d       = done;
        overflow_d   = overflow;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d      = FILL;
                    byte_ready_d = 1'b1;
                    cnt_d        = '0;
                    word_d       = '0;
                    last_d       = 1'b0;
                    mem_addr_d   = '0;
                    word_count_d = '0;
                    done_d       = 1'b0;
                    overflow_d   = 1'b0;
                end
            end

            FILL: begin
                if (byte_valid && byte_ready) begin
                    word_d = packed_word;
                    cnt_d  = cnt_inc;
                    if (cnt_inc == CHAR_PART_C || byte_last) begin
                        state_d      = WRITE;
                        byte_ready_d = 1'b0;
                        mem_wr_d     = 1'b1;
                        mem_data_d   = packed_word << {pad_bytes, 3'b000};
                        last_d       = byte_last;
                    end
                end
            end

            WRITE: begin
                word_count_d = word_count + 1'b1;
                cnt_d        = '0;
                word_d       = '0;
                if (last_q) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else if (mem_addr == LAST_ADDR) begin
                    // Memory full with more stream pending: stop, never wrap.
                    state_d    = DONE;
                    done_d     = 1'b1;
                    overflow_d = 1'b1;
                end else begin
                    state_d      = FILL;
                    byte_ready_d = 1'b1;
                    mem_addr_d   = mem_addr + 1'b1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            word_q     <= '0;
            last_q     <= 1'b0;
            byte_ready <= 1'b0;
            mem_wr     <= 1'b0;
            mem_addr   <= '0;
            mem_data   <= '0;
            word_count <= '0;
            done       <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments, so every register samples the
            // values from before this edge regardless of statement order.
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            word_q     <= word_d;
            last_q     <= last_d;
            byte_ready <= byte_ready_d;
            mem_wr     <= mem_wr_d;
            mem_addr   <= mem_addr_d;
            mem_data   <= mem_data_d;
            word_count <= word_count_d;
            done       <= done_d;
            overflow   <= overflow_d;
        end
    end

endmodule

// File: tb/tb_mem_stream_loader.sv
// Self-checking bench for mem_stream_loader. A reference model turns each
// byte stream into the list of expected memory writes (queue); a monitor
// compares every mem_wr cycle against the head of that queue.
module tb_mem_stream_loader;

    localparam int ADDR_LEN  = 11;
    localparam int DATA_LEN  = 40;
    localparam int CHAR_PART = DATA_LEN / 8;
    localparam int ADDRS     = 2 ** ADDR_LEN;

    typedef logic [7:0] byte_t;
    typedef struct {
        logic [ADDR_LEN-1:0] addr;
        logic [DATA_LEN-1:0] data;
    } wr_t;

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic                byte_valid;
    logic [7:0]          byte_data;
    logic                byte_last;
    logic                byte_ready;
    logic                mem_wr;
    logic [ADDR_LEN-1:0] mem_addr;
    logic [DATA_LEN-1:0] mem_data;
    logic [ADDR_LEN:0]   word_count;
    logic                done;
    logic                overflow;

    mem_stream_loader #(.ADDR_LEN(ADDR_LEN), .DATA_LEN(DATA_LEN)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_last  (byte_last),
        .byte_ready (byte_ready),
        .mem_wr     (mem_wr),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .word_count (word_count),
        .done       (done),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    int  n_checks = 0;
    int  n_fail   = 0;
    int  cycle    = 0;
    wr_t exp_q[$];
    int  wr_cycles[$];

    always @(posedge clk) cycle++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every write cycle must match the next expected write.
    always @(negedge clk) begin
        if (rst === 1'b1 && mem_wr === 1'b1) begin
            wr_t e;
            wr_cycles.push_back(cycle);
            if (exp_q.size() == 0) begin
                check("spurious mem_wr", 64'(mem_wr), 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("write addr", 64'(mem_addr), 64'(e.addr));
                check("write data", 64'(mem_data), 64'(e.data));
            end
        end
    end

    // Reference model: chop the stream into CHAR_PART-byte words (short last
    // word zero-padded on the right), addresses from 0, at most ADDRS words.
    task automatic model_load(input byte_t bytes[$], output int nwords,
                              output bit ovf, output int n_accept);
        int n = bytes.size();
        int words_in_stream = (n + CHAR_PART - 1) / CHAR_PART;
        nwords   = (words_in_stream > ADDRS) ? ADDRS : words_in_stream;
        ovf      = words_in_stream > ADDRS;
        n_accept = (n > ADDRS * CHAR_PART) ? ADDRS * CHAR_PART : n;
        for (int w = 0; w < nwords; w++) begin
            wr_t e;
            logic [DATA_LEN-1:0] d = '0;
            for (int k = 0; k < CHAR_PART; k++) begin
                int idx = w * CHAR_PART + k;
                d = (d << 8) | DATA_LEN'(idx < n ? bytes[idx] : 8'h00);
            end
            e.addr = ADDR_LEN'(w);
            e.data = d;
            exp_q.push_back(e);
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Offer one byte (called at a negedge); returns at the negedge after the
    // edge that accepted it.
    task automatic send_byte(input byte_t b, input bit last, output bit ok);
        byte_valid = 1'b1;
        byte_data  = b;
        byte_last  = last;
        ok = 1'b0;
        for (int t = 0; t < 50; t++) begin
            if (byte_ready === 1'b1) begin
                @(posedge clk);
                @(negedge clk);
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        byte_valid = 1'b0;
        byte_last  = 1'b0;
        if (!ok) check("byte_ready timeout", 64'(byte_ready), 64'd1);
    endtask

    task automatic send_stream(input byte_t bytes[$], input int n_send,
                               input bit has_last, input bit gaps);
        bit ok;
        for (int i = 0; i < n_send; i++) begin
            int ng = gaps ? int'($urandom_range(1, 3)) : 0;
            for (int j = 0; j < ng; j++) begin
                // Only the cycle right after a word completes has ready low.
                bit exp_rdy = (j > 0) || (i == 0) || (i % CHAR_PART != 0);
                check("byte_ready in gap", 64'(byte_ready), 64'(exp_rdy));
                byte_valid = 1'b0;
                @(negedge clk);
            end
            send_byte(bytes[i], has_last && (i == n_send - 1), ok);
            if (!ok) return;
            if (n_send == 1 && has_last) begin
                check("single: mem_wr after transfer", 64'(mem_wr), 64'd1);
                check("single: done not yet", 64'(done), 64'd0);
                @(negedge clk);
                check("single: done next cycle", 64'(done), 64'd1);
            end
        end
    endtask

    task automatic wait_done();
        for (int t = 0; t < 200; t++) begin
            if (done === 1'b1) return;
            @(negedge clk);
        end
        check("done timeout", 64'(done), 64'd1);
    endtask

    task automatic run_load(input byte_t bytes[$], input bit has_last, input bit gaps);
        int nwords, n_accept;
        bit ovf;
        model_load(bytes, nwords, ovf, n_accept);
        wr_cycles.delete();
        do_start();
        send_stream(bytes, n_accept, has_last, gaps);
        wait_done();
        check("word_count", 64'(word_count), 64'(nwords));
        check("done", 64'(done), 64'd1);
        check("overflow", 64'(overflow), 64'(ovf));
        check("byte_ready after load", 64'(byte_ready), 64'd0);
        check("pending writes", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " byte_ready"}, 64'(byte_ready), 64'd0);
        check({tag, " mem_wr"},     64'(mem_wr),     64'd0);
        check({tag, " mem_addr"},   64'(mem_addr),   64'd0);
        check({tag, " mem_data"},   64'(mem_data),   64'd0);
        check({tag, " word_count"}, 64'(word_count), 64'd0);
        check({tag, " done"},       64'(done),       64'd0);
        check({tag, " overflow"},   64'(overflow),   64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        byte_t s[$];
        byte_t seq10[$];
        bit    ok;
        int    nw, na;
        bit    ov;

        rst = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = '0; byte_last = 1'b0;
        #2 rst = 1'b0;
        @(negedge clk); @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b1;
        @(negedge clk);

        // Ten bytes back-to-back: two full words, writes six cycles apart.
        for (int i = 1; i <= 10; i++) seq10.push_back(byte_t'(i));
        run_load(seq10, 1'b1, 1'b0);
        check("write pulses", 64'(wr_cycles.size()), 64'd2);
        if (wr_cycles.size() == 2)
            check("write spacing", 64'(wr_cycles[1] - wr_cycles[0]), 64'd6);

        // Partial final word.
        s.delete();
        for (int i = 0; i < 7; i++) s.push_back(byte_t'(8'hA1 + i));
        run_load(s, 1'b1, 1'b0);

        // Single byte, done timing checked in send_stream.
        s.delete();
        s.push_back(8'hFF);
        run_load(s, 1'b1, 1'b0);

        // Gappy valid with the same ten bytes.
        run_load(seq10, 1'b1, 1'b1);
        check("gappy write pulses", 64'(wr_cycles.size()), 64'd2);

        // Random streams.
        for (int r = 0; r < 4; r++) begin
            int len = $urandom_range(1, 32);
            s.delete();
            for (int i = 0; i < len; i++) s.push_back(byte_t'($urandom));
            run_load(s, 1'b1, r[0]);
        end

        // Overflow: 2049 full words, no byte_last.
        s.delete();
        for (int i = 0; i < (ADDRS + 1) * CHAR_PART; i++) s.push_back(byte_t'($urandom));
        run_load(s, 1'b0, 1'b0);
        check("overflow addr no wrap", 64'(mem_addr), 64'(ADDRS - 1));
        byte_valid = 1'b1;
        byte_data  = 8'h5A;
        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            check("byte_ready held low", 64'(byte_ready), 64'd0);
        end
        byte_valid = 1'b0;

        // Reset while word 3 is being written.
        s.delete();
        for (int i = 0; i < 3 * CHAR_PART; i++) s.push_back(byte_t'($urandom));
        model_load(s, nw, ov, na);
        do_start();
        send_stream(s, na, 1'b0, 1'b0);
        check("mid-load mem_wr", 64'(mem_wr), 64'd1);
        check("mid-load mem_addr", 64'(mem_addr), 64'd2);
        #1 rst = 1'b0;
        #1 check_reset_outputs("async reset");
        check("writes before reset", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        run_load(seq10, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
